// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - load-use / early-branch hazard scheduler with forwarding selects
// Ports:
//   clk, rstn                      clock, async active-low reset
//   id_valid, id_rs1/2, id_use_rs1/2, id_rd, id_reg_write, id_mem_read,
//   id_early, id_pc_src            decoded ID-stage instruction
//   stall, flush_if_id             pipeline control (combinational)
//   rs1/2_fwd_id                   ID operand select (combinational)
//   rs1/2_fwd_ex                   EX operand select (registered)
//   stall_cnt, flush_cnt           saturating event counters
//   hold_err                       sticky over-long stall flag
module hazard_sched (
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_early,
  input  logic        id_pc_src,
  output logic        stall,
  output logic        flush_if_id,
  output logic [1:0]  rs1_fwd_id,
  output logic [1:0]  rs2_fwd_id,
  output logic [1:0]  rs1_fwd_ex,
  output logic [1:0]  rs2_fwd_ex,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        hold_err
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } slot_t;

  typedef enum logic {RUN, HOLD} state_t;

  slot_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  state_t      state_q, state_d;
  logic [1:0]  hold_cnt_q, hold_cnt_d;
  logic        hold_err_q, hold_err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [1:0]  rs1_fwd_ex_q, rs1_fwd_ex_d;
  logic [1:0]  rs2_fwd_ex_q, rs2_fwd_ex_d;

  // x0 is hardwired zero, so a write to it never creates a dependency.
  function automatic logic hit(slot_t s, logic [4:0] src, logic use_src);
    return use_src & s.v & s.rw & (s.rd != 5'd0) & (s.rd == src);
  endfunction

  function automatic logic [1:0] sel_id(slot_t m, slot_t w, logic [4:0] src, logic use_src);
    if (hit(m, src, use_src) && !m.ld) return 2'b01;
    else if (hit(w, src, use_src))     return 2'b10;
    else                               return 2'b00;
  endfunction

  // Encoding is relative to where the ID instruction will sit after the edge:
  // today's MEM producer will be in WB, today's EX producer in MEM.
  function automatic logic [1:0] sel_ex(slot_t e, slot_t m, logic [4:0] src, logic use_src);
    if (hit(m, src, use_src))              return 2'b10;
    else if (hit(e, src, use_src) && !e.ld) return 2'b01;
    else                                    return 2'b00;
  endfunction

  logic ex_hit, ex_ld_hit, mem_ld_hit;

  always_comb begin
    ex_hit     = hit(ex_q, id_rs1, id_use_rs1) | hit(ex_q, id_rs2, id_use_rs2);
    ex_ld_hit  = ex_hit & ex_q.ld;
    mem_ld_hit = (hit(mem_q, id_rs1, id_use_rs1) | hit(mem_q, id_rs2, id_use_rs2)) & mem_q.ld;

    // Early consumers need the value in ID, so any producer still in EX and
    // a load still in MEM are both too late.
    stall       = id_valid & (id_early ? (ex_hit | mem_ld_hit) : ex_ld_hit);
    flush_if_id = id_valid & id_pc_src & ~stall;
    rs1_fwd_id  = sel_id(mem_q, wb_q, id_rs1, id_use_rs1);
    rs2_fwd_id  = sel_id(mem_q, wb_q, id_rs2, id_use_rs2);
  end

  always_comb begin
    ex_d         = stall ? '0 : {id_valid, id_rd, id_reg_write, id_mem_read};
    mem_d        = ex_q;
    wb_d         = mem_q;
    rs1_fwd_ex_d = stall ? 2'b00 : sel_ex(ex_q, mem_q, id_rs1, id_use_rs1);
    rs2_fwd_ex_d = stall ? 2'b00 : sel_ex(ex_q, mem_q, id_rs2, id_use_rs2);
    stall_cnt_d  = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d  = (flush_if_id && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    // Counter value equals the number of stall cycles already spent, so it
    // reads 3 on the fourth consecutive stall.
    hold_err_d   = hold_err_q | (stall & (hold_cnt_q == 2'd3));
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      RUN: begin
        hold_cnt_d = 2'd0;
        if (stall) begin
          state_d    = HOLD;
          hold_cnt_d = 2'd1;
        end
      end
      HOLD: begin
        if (stall) begin
          hold_cnt_d = (hold_cnt_q == 2'd3) ? 2'd3 : hold_cnt_q + 2'd1;
        end else begin
          state_d    = RUN;
          hold_cnt_d = 2'd0;
        end
      end
      default: begin
        state_d    = RUN;
        hold_cnt_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      state_q      <= RUN;
      hold_cnt_q   <= 2'd0;
      hold_err_q   <= 1'b0;
      stall_cnt_q  <= 16'd0;
      flush_cnt_q  <= 16'd0;
      rs1_fwd_ex_q <= 2'b00;
      rs2_fwd_ex_q <= 2'b00;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_err_q   <= hold_err_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      rs1_fwd_ex_q <= rs1_fwd_ex_d;
      rs2_fwd_ex_q <= rs2_fwd_ex_d;
    end
  end

  assign rs1_fwd_ex = rs1_fwd_ex_q;
  assign rs2_fwd_ex = rs2_fwd_ex_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign hold_err   = hold_err_q;

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - self-checking bench for hazard_sched
module tb_hazard_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_early, id_pc_src;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall, flush_if_id, hold_err;
  logic [1:0]  rs1_fwd_id, rs2_fwd_id, rs1_fwd_ex, rs2_fwd_ex;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_sched dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_early(id_early), .id_pc_src(id_pc_src),
    .stall(stall), .flush_if_id(flush_if_id),
    .rs1_fwd_id(rs1_fwd_id), .rs2_fwd_id(rs2_fwd_id),
    .rs1_fwd_ex(rs1_fwd_ex), .rs2_fwd_ex(rs2_fwd_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hold_err(hold_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cur_row = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (row %0d): got %0h expected %0h", nm, cur_row, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
                       input int rd, input logic rw, input logic ld, input logic early, input logic pc);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = 5'(rd); id_reg_write = rw; id_mem_read = ld; id_early = early; id_pc_src = pc;
  endtask

  // Reference model: a list of in-flight writers indexed by how many
  // instructions ahead of ID they are (0 = directly ahead, in EX).
  typedef struct {bit v; int rd; bit rw; bit ld;} ins_t;
  ins_t ahead[3];
  int   m_sc, m_fc, m_run;
  bit   m_err;
  int   m_x1, m_x2;

  task automatic m_reset();
    for (int i = 0; i < 3; i++) ahead[i] = '{0, 0, 0, 0};
    m_sc = 0; m_fc = 0; m_run = 0; m_err = 0; m_x1 = 0; m_x2 = 0;
  endtask

  function automatic bit writes(int d, int src, bit u);
    return u && ahead[d].v && ahead[d].rw && ahead[d].rd != 0 && ahead[d].rd == src;
  endfunction

  function automatic bit needs(int d);
    return writes(d, int'(id_rs1), id_use_rs1) || writes(d, int'(id_rs2), id_use_rs2);
  endfunction

  // Value must exist by the stage where it is consumed: loads produce at MEM
  // end, ALU ops at EX end; early consumers read in ID, ordinary ones in EX.
  function automatic bit m_stall();
    if (!id_valid) return 0;
    if (id_early) return needs(0) || (needs(1) && ahead[1].ld);
    return needs(0) && ahead[0].ld;
  endfunction

  function automatic int m_fid(int src, bit u);
    if (writes(1, src, u) && !ahead[1].ld) return 1;
    if (writes(2, src, u)) return 2;
    return 0;
  endfunction

  function automatic int m_fex(int src, bit u);
    if (writes(1, src, u)) return 2;
    if (writes(0, src, u) && !ahead[0].ld) return 1;
    return 0;
  endfunction

  task automatic m_edge();
    bit s, f;
    s = m_stall();
    f = id_valid && id_pc_src && !s;
    m_x1 = s ? 0 : m_fex(int'(id_rs1), id_use_rs1);
    m_x2 = s ? 0 : m_fex(int'(id_rs2), id_use_rs2);
    if (s && m_sc < 65535) m_sc++;
    if (f && m_fc < 65535) m_fc++;
    if (s && m_run >= 3) m_err = 1;
    m_run = s ? m_run + 1 : 0;
    ahead[2] = ahead[1];
    ahead[1] = ahead[0];
    if (s) ahead[0] = '{0, 0, 0, 0};
    else   ahead[0] = '{id_valid, int'(id_rd), id_reg_write, id_mem_read};
  endtask

  // One cycle checked against the model: inputs already driven.
  task automatic step_model();
    bit s;
    #2;
    s = m_stall();
    chk("stall", 32'(stall), 32'(s));
    chk("flush_if_id", 32'(flush_if_id), 32'(id_valid && id_pc_src && !s));
    chk("rs1_fwd_id", 32'(rs1_fwd_id), 32'(m_fid(int'(id_rs1), id_use_rs1)));
    chk("rs2_fwd_id", 32'(rs2_fwd_id), 32'(m_fid(int'(id_rs2), id_use_rs2)));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
    chk("hold_err", 32'(hold_err), 32'(m_err));
    m_edge();
    @(posedge clk);
    #1;
    chk("rs1_fwd_ex", 32'(rs1_fwd_ex), 32'(m_x1));
    chk("rs2_fwd_ex", 32'(rs2_fwd_ex), 32'(m_x2));
  endtask

  typedef struct {
    logic v; int rs1; int rs2; logic u1; logic u2; int rd; logic rw; logic ld; logic early; logic pc;
    logic e_stall; logic e_flush; int e_f1; int e_f2; int e_x1; int e_x2; int e_sc; int e_fc;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
                     input int rd, input logic rw, input logic ld, input logic early, input logic pc,
                     input logic es, input logic ef, input int f1, input int f2,
                     input int x1, input int x2, input int sc, input int fc);
    vec_t r;
    r = '{v, rs1, rs2, u1, u2, rd, rw, ld, early, pc, es, ef, f1, f2, x1, x2, sc, fc};
    tbl.push_back(r);
  endtask

  task automatic nop(input int sc, input int fc);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, sc, fc);
  endtask

  initial begin
    m_reset();
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_fwd_ex", {28'd0, rs1_fwd_ex, rs2_fwd_ex}, 32'd0);
    chk("rst_hold_err", 32'(hold_err), 32'd0);
    drive(1, 1, 2, 1, 1, 0, 0, 0, 1, 1);
    #1;
    chk("rst_comb_flush", 32'(flush_if_id), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // v rs1 rs2 u1 u2 rd rw ld early pc | stall flush f1 f2 x1 x2 sc fc
    row(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // add x5
    row(1, 5, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);   // beq x5,x0 stalls
    row(1, 5, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 2, 0, 1, 0);   // MEM forward
    nop(1, 0); nop(1, 0);
    row(1, 1, 0, 1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);   // lw x6
    row(1, 6, 1, 1, 1, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);   // add x7,x6,x1 load-use
    row(1, 6, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0);
    nop(2, 0); nop(2, 0);
    row(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);   // lw x7
    row(1, 7, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2, 0);   // beq x7 two stalls
    row(1, 7, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 3, 0);
    row(1, 7, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 4, 0);
    nop(4, 0); nop(4, 0);
    row(1, 1, 2, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 4, 0);   // taken branch
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 1);   // invalid ID kills flush
    nop(4, 1);
    row(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1);   // addi x0
    row(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4, 1);   // beq x0,x0
    row(1, 1, 0, 1, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1);   // lw x9
    row(1, 9, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 4, 1);   // taken beq x9: stall beats flush
    row(1, 9, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 5, 1);
    row(1, 9, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 2, 0, 0, 0, 6, 1);
    nop(6, 2); nop(6, 2);
    row(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 2);   // add x3
    row(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 2);   // sub x4,x3,x3
    row(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 2, 1, 6, 2);   // and x5,x3,x4
    nop(6, 2); nop(6, 2);

    foreach (tbl[i]) begin
      cur_row = i;
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
            tbl[i].rd, tbl[i].rw, tbl[i].ld, tbl[i].early, tbl[i].pc);
      #2;
      chk("tbl_stall", 32'(stall), 32'(tbl[i].e_stall));
      chk("tbl_flush", 32'(flush_if_id), 32'(tbl[i].e_flush));
      chk("tbl_rs1_fwd_id", 32'(rs1_fwd_id), 32'(tbl[i].e_f1));
      chk("tbl_rs2_fwd_id", 32'(rs2_fwd_id), 32'(tbl[i].e_f2));
      chk("tbl_stall_cnt", 32'(stall_cnt), 32'(tbl[i].e_sc));
      chk("tbl_flush_cnt", 32'(flush_cnt), 32'(tbl[i].e_fc));
      m_edge();
      @(posedge clk);
      #1;
      chk("tbl_rs1_fwd_ex", 32'(rs1_fwd_ex), 32'(tbl[i].e_x1));
      chk("tbl_rs2_fwd_ex", 32'(rs2_fwd_ex), 32'(tbl[i].e_x2));
    end
    cur_row = -1;
    chk("tbl_hold_err", 32'(hold_err), 32'd0);

    // Reset during the first stall cycle of lw -> beq.
    drive(1, 1, 0, 1, 0, 7, 1, 1, 0, 0);
    step_model();
    drive(1, 7, 0, 1, 1, 0, 0, 0, 1, 0);
    #2;
    chk("pre_rst_stall", 32'(stall), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("mid_rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("mid_rst_fwd_ex", {28'd0, rs1_fwd_ex, rs2_fwd_ex}, 32'd0);
    m_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step_model();
    chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Randomized traffic against the model; a small register range makes
    // dependencies frequent.
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 9) < 8, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
            $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
      step_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
